lfsr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit maximal-length LFSR among NREQ requesters.
- Each granted request advances the LFSR exactly once and delivers the new value to the winner over a valid/ack handshake.
- Supports software re-seeding while idle, with a guard against the all-zero lock-up state.
- Sits between the pseudo-random consumers of the sequential block group and the shared LFSR datapath.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_arbiter_lfsr4_core.sv | 38 +++
 rtl/lfsr_arbiter.sv | 108 ++++++++++
 tb/tb_lfsr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR arbiter slice.
// State encoding, default seed, tap positions and the 4-bit step function.
package lfsr_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    localparam logic [3:0] DEFAULT_SEED = 4'b1000;

    localparam int TAP_HI = 3;
    localparam int TAP_LO = 0;

    function automatic logic [3:0] lfsr_next(input logic [3:0] r);
        return {r[2:0], r[TAP_HI] ^ r[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_arbiter_lfsr4_core.sv
// 4-bit maximal-length LFSR register with load and zero-seed guard.
// Load has priority over step; an all-zero load value becomes SEED.
module lfsr4_core
    import lfsr_pkg::*;
#(
    parameter logic [3:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       step,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val == 4'b0000) ? SEED : load_val;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one 4-bit LFSR among NREQ requesters.
// Define LFSR_ARB_FREE_RUN_EN to let the LFSR step in IDLE as well.
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int         NREQ = 4,
    parameter logic [3:0] SEED = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
    input  logic            seed_load,
    input  logic [3:0]      seed_in,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [3:0]      rnd_data,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    logic          lfsr_step;
    logic          lfsr_load;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        lfsr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (found) begin
                    win_d   = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (ack) begin
                    ptr_d   = PW'((int'(win_q) + 1) % NREQ);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef LFSR_ARB_FREE_RUN_EN
    assign lfsr_step = (state_q != ST_DELIVER);
`else
    assign lfsr_step = (state_q == ST_GRANT);
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    lfsr4_core #(
        .SEED(SEED)
    ) u_core (
        .clk     (clk),
        .clear   (clear),
        .step    (lfsr_step),
        .load    (lfsr_load),
        .load_val(seed_in),
        .q       (rnd_data)
    );

    assign busy      = (state_q != ST_IDLE);
    assign rnd_valid = (state_q == ST_DELIVER);
    assign gnt       = busy ? (NREQ'(1) << win_q) : '0;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Randomized self-checking bench for lfsr_arbiter against a sequence-table model.
module tb_lfsr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic         seed_load = 1'b0;
    logic [3:0]   seed_in = '0;
    logic [N-1:0] gnt;
    logic         rnd_valid;
    logic [3:0]   rnd_data;
    logic         busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    lfsr_arbiter #(.NREQ(N)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (req),
        .ack      (ack),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .gnt      (gnt),
        .rnd_valid(rnd_valid),
        .rnd_data (rnd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [3:0] seq [15] = '{
        4'b1000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
        4'b1110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
        4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100
    };

    // Model: position in the published sequence, phase 0/1/2, pointer, winner.
    int m_pos = 0;
    int m_phase = 0;
    int m_ptr = 0;
    int m_win = 0;

    function automatic int seq_idx(input logic [3:0] v);
        for (int i = 0; i < 15; i++) begin
            if (seq[i] == v) return i;
        end
        return 0;
    endfunction

    function automatic int first_win(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_pos = 0;
            m_phase = 0;
            m_ptr = 0;
            m_win = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (seed_load) begin
                        m_pos = seq_idx(seed_in == 4'b0 ? 4'b1000 : seed_in);
                    end else begin
`ifdef LFSR_ARB_FREE_RUN_EN
                        m_pos = (m_pos + 1) % 15;
`endif
                        if (req != '0) begin
                            m_win = first_win(req, m_ptr);
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    m_pos = (m_pos + 1) % 15;
                    m_phase = 2;
                end
                default: begin
                    if (ack) begin
                        m_ptr = (m_win + 1) % N;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = (m_phase != 0) ? N'(1 << m_win) : '0;
            chk("m_gnt", 8'(gnt), 8'(eg));
            chk("m_valid", 8'(rnd_valid), 8'(m_phase == 2));
            chk("m_busy", 8'(busy), 8'(m_phase != 0));
            chk("m_data", 8'(rnd_data), 8'(seq[m_pos]));
        end
    end

    task automatic txn(input logic [N-1:0] r, input bit lit,
                       input logic [N-1:0] eg, input logic [3:0] ed,
                       input bit drop);
        req = r;
        @(negedge clk);
        if (lit) begin
            chk("t_gnt", 8'(gnt), 8'(eg));
            chk("t_busy", 8'(busy), 8'd1);
        end
        if (drop) req = '0;
        @(negedge clk);
        if (lit) begin
            chk("t_valid", 8'(rnd_valid), 8'd1);
            chk("t_data", 8'(rnd_data), 8'(ed));
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (lit) chk("t_idle", 8'(busy), 8'd0);
    endtask

    task automatic reset_check(input string nm);
        chk({nm, "_gnt"}, 8'(gnt), 8'd0);
        chk({nm, "_valid"}, 8'(rnd_valid), 8'd0);
        chk({nm, "_busy"}, 8'(busy), 8'd0);
        chk({nm, "_data"}, 8'(rnd_data), 8'b1000);
    endtask

    initial begin
        #3 clear = 1'b1;
        #1 reset_check("rst");
        chk_en = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        txn(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);

        #2 clear = 1'b1;
        #1 reset_check("rst2");
        @(negedge clk);
        clear = 1'b0;
        txn(4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0);
        txn(4'b1111, 1'b1, 4'b0010, 4'b0011, 1'b0);
        txn(4'b1111, 1'b1, 4'b0100, 4'b0111, 1'b0);
        txn(4'b1111, 1'b1, 4'b1000, 4'b1111, 1'b0);
        txn(4'b1111, 1'b1, 4'b0001, 4'b1110, 1'b1);

        seed_in = 4'b0000;
        seed_load = 1'b1;
        @(negedge clk);
        chk("seed_zero", 8'(rnd_data), 8'b1000);
        seed_in = 4'b1011;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed_1011", 8'(rnd_data), 8'b1011);
        txn(4'b0100, 1'b1, 4'b0100, 4'b0110, 1'b1);

        req = 4'b0010;
        seed_in = 4'b0101;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        chk("prio_busy", 8'(busy), 8'd0);
        chk("prio_data", 8'(rnd_data), 8'b0101);
        @(negedge clk);
        chk("prio_gnt", 8'(gnt), 8'b0010);
        req = '0;
        @(negedge clk);
        chk("prio_dat2", 8'(rnd_data), 8'b1011);
        seed_in = 4'b0011;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        chk("ign_data", 8'(rnd_data), 8'b1011);
        chk("ign_valid", 8'(rnd_valid), 8'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        chk("noqueue", 8'(rnd_data), 8'b1011);

        req = 4'b1111;
        @(negedge clk);
        chk("mid_gnt", 8'(gnt), 8'b0100);
        @(negedge clk);
        chk("mid_data", 8'(rnd_data), 8'b0110);
        #2 clear = 1'b1;
        #1 reset_check("mid");
        @(negedge clk);
        clear = 1'b0;
        txn(4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);

        #2 clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 15; i++) begin
            txn(N'($urandom_range(1, 15)), 1'b0, '0, '0, 1'b1);
        end
        chk("wrap", 8'(rnd_data), 8'b1000);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            seed_load = ($urandom_range(0, 7) == 0);
            seed_in = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 clear = 1'b1;
                #2 clear = 1'b0;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
